bcd_to_bin_seq: RTL and testbench
=================================

Name: bcd_to_bin_seq

Overview:
- Multi-cycle converter from packed BCD to binary. It is the inverse of the lab's binary-to-decimal display path.
- Takes DIGITS BCD digits, for example tens/ones entered on SW.
- Produces an unsigned binary value using reverse double-dabble (shift right, subtract 3).
- Uses a start/busy/done handshake. Feeds arithmetic blocks that consume operands entered in decimal.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in (>=1).
- BIN_W, 7, width of bin_out. Must satisfy 2^BIN_W >= 10^DIGITS (7 for 2 digits, 10 for 3).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of bcd_in; sampled on rising edge.
- bcd_in  input  4*DIGITS  packed BCD; nibble 0 = ones digit, nibble DIGITS-1 = most significant digit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin_out/err are updated.
- err  output  1  result flag: some input nibble was >9; held until next accepted start.
- bin_out  output  BIN_W  converted value; held until next accepted start.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy=0, done=0, err=0, bin_out=0.
  - Shift register and iteration counter are cleared.
  - Reset during CONV aborts the conversion; no done pulse is produced.
- States: IDLE, CONV, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1, bcd_in is captured, regardless of whether it is valid.
  - If every nibble is <=9:
    - Load shift register {bcd_part = bcd_in, bin_part = 0} (width 4*DIGITS+BIN_W).
    - Set counter=0 and go to CONV.
  - If any nibble is >9:
    - Go directly to DONE with err<=1 and bin_out<=0.
    - Latency is 1 edge.
- CONV:
  - busy=1.
  - Each edge performs one iteration:
    - Shift the whole register right by 1; the LSB of bcd_part enters the MSB of bin_part.
    - Then, for each BCD nibble of the shifted value, if nibble >=8, subtract 3.
    - Shift and correction are combinational within the same edge.
  - The counter increments each edge.
  - On the BIN_W-th iteration edge, go to DONE and set bin_out<=bin_part after that iteration and err<=0.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation; no dropped request).
- Latency:
  - Valid input: start edge at cycle 0, done high during cycle BIN_W+1 (default: 8 cycles after the start edge).
  - Invalid input: done high in the cycle after the start edge.
- Handshake:
  - start while busy=1 is ignored; it is neither queued nor restarts the conversion.
  - bcd_in may change freely after the start edge.
- bin_out and err change only on the DONE-entry edge (or on reset). They are stable at all other times.
- Arithmetic:
  - Unsigned.
  - Result = sum of digit_i·10^i, in range 0..10^DIGITS-1.
  - No overflow is possible given the BIN_W constraint. An elaboration-time check of BIN_W is required.
- done and busy are never both 1.

Test Plan:
- Reset, then start with bcd_in=8'h42 (DIGITS=2) -> busy=1 for 7 cycles; done pulse 8 cycles after the start edge; bin_out=7'd42 (0x2A); err=0.
- Boundary values 8'h00 -> bin_out=0; 8'h99 -> bin_out=99; 8'h09 -> 9; 8'h10 -> 10. Exhaustive sweep 00..99 is checked against a reference model.
- Invalid digit 8'h3A -> done in the next cycle; err=1; bin_out=0. A subsequent start with 8'h15 -> err=0, bin_out=15.
- Start 8'h73, then pulse start with 8'h11 at cycle 3 of CONV -> second start ignored; result 73; exactly one done pulse.
- Start 8'h58, assert rst at cycle 4 -> immediately busy=0, bin_out=0, no done pulse. After release, start 8'h58 -> 58.
- Back-to-back: start 8'h21, hold start=1 with bcd_in=8'h64 during the done cycle -> second conversion begins with no IDLE gap; results 21 then 64.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Multi-cycle packed-BCD to unsigned binary converter using
//               reverse double-dabble. It performs one shift-right step per
//               clock, and then subtracts 3 from every BCD nibble that is 8 or
//               more. It uses a start/busy/done handshake.
// Ports       : clk     - system clock, rising edge
//               rst     - asynchronous active-high reset
//               start   - conversion request, sampled in IDLE and DONE
//               bcd_in  - packed BCD, nibble 0 = ones digit
//               busy    - conversion in progress
//               done    - one-cycle pulse when bin_out/err update
//               err     - some input nibble was >9 (held until next start)
//               bin_out - converted value (held until next start)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam longint MAX_DEC   = pow10(DIGITS);
  localparam longint BIN_RANGE = longint'(1) << BIN_W;

  // Reject parameter sets that could not represent the largest decimal input.
  generate
    if (DIGITS < 1) begin : g_digits_check
      $error("bcd_to_bin_seq: DIGITS must be >= 1");
    end
    if (BIN_RANGE < MAX_DEC) begin : g_bin_w_check
      $error("bcd_to_bin_seq: BIN_W too small, need 2**BIN_W >= 10**DIGITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [SR_W-1:0]    sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [BIN_W-1:0]   bin_q;

  logic [SR_W-1:0]    sr_d;
  logic               in_valid_d;

  // The input is accepted only if every nibble is a legal decimal digit.
  always_comb begin
    in_valid_d = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) in_valid_d = 1'b0;
    end
  end

  // This is one reverse double-dabble iteration. A nibble that is 8 or more
  // after the shift held an odd digit value in the higher decade. Subtracting
  // 3 removes the excess, because 16/2 - 10/2 = 3.
  always_comb begin
    sr_d = sr_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_d[BIN_W + 4*i +: 4] >= 4'd8)
        sr_d[BIN_W + 4*i +: 4] = sr_d[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE, so back-to-back
        // operation does not lose a request.
        S_IDLE, S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            cnt_q <= '0;
            if (in_valid_d) begin
              sr_q    <= {bcd_in, {BIN_W{1'b0}}};
              busy_q  <= 1'b1;
              state_q <= S_CONV;
            end else begin
              sr_q    <= '0;
              err_q   <= 1'b1;
              bin_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_CONV: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            bin_q   <= sr_d[BIN_W-1:0];
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_bin_seq
// Description : Self-checking bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7).
//               It compares results against a decimal-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;
  localparam int BW     = 4*DIGITS;

  logic              clk;
  logic              rst;
  logic              start;
  logic [BW-1:0]     bcd_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [BIN_W-1:0]  bin_out;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // The reference model computes the sum of digit*10^i and sets an error flag
  // if any digit is greater than 9.
  function automatic int ref_val(input logic [BW-1:0] b);
    int v, w;
    v = 0; w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + int'(b[4*i +: 4]) * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic bit ref_err(input logic [BW-1:0] b);
    bit e;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives start for one edge. On return, the bench is at the first
  // falling edge after the start edge (cycle 1).
  task automatic launch(input logic [BW-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = BW'($urandom);
  endtask

  // Waits for done and checks the result, latency, busy cycles and
  // done/busy exclusivity. It can inject a start at CONV cycle inj_at.
  // If chain is set, it holds start during the done cycle so that the next
  // request begins immediately.
  task automatic finish(input logic [BW-1:0] b, input string tag,
                        input int inj_at, input logic [BW-1:0] inj,
                        input bit chain, input logic [BW-1:0] chain_b);
    int lat, busy_n;
    bit both;
    bit e;
    lat = 1; busy_n = 0; both = 1'b0;
    e = ref_err(b);
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      if (lat == inj_at) begin
        start = 1'b1; bcd_in = inj;
      end else if (lat == inj_at + 1) begin
        start = 1'b0; bcd_in = BW'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1 && done === 1'b1) both = 1'b1;
    chk({tag, ".latency"}, lat, e ? 1 : BIN_W + 1);
    chk({tag, ".busy_cycles"}, busy_n, e ? 0 : BIN_W);
    chk({tag, ".bin_out"}, bin_out, e ? 0 : ref_val(b));
    chk({tag, ".err"}, err, e);
    chk({tag, ".busy_done_excl"}, both, 0);
    if (chain) begin
      start = 1'b1; bcd_in = chain_b;
      @(negedge clk);
      start = 1'b0; bcd_in = BW'($urandom);
      chk({tag, ".chain_busy"}, busy, !ref_err(chain_b));
      chk({tag, ".chain_hold_bin"}, bin_out, e ? 0 : ref_val(b));
    end else begin
      @(negedge clk);
      chk({tag, ".done_pulse_end"}, done, 0);
      chk({tag, ".hold_bin"}, bin_out, e ? 0 : ref_val(b));
    end
  endtask

  task automatic conv(input logic [BW-1:0] b, input string tag);
    launch(b);
    finish(b, tag, -5, '0, 1'b0, '0);
  endtask

  initial begin
    int dn;
    logic [BW-1:0] r;
    rst = 1'b1; start = 1'b0; bcd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.err", err, 0);
    chk("reset.bin_out", bin_out, 0);
    rst = 1'b0;

    conv(8'h42, "d42");
    conv(8'h00, "d00");
    conv(8'h99, "d99");
    conv(8'h09, "d09");
    conv(8'h10, "d10");

    conv(8'h3A, "inv3A");
    conv(8'h15, "after_inv15");

    // A second start during CONV must be ignored. Exactly one done pulse
    // is allowed.
    launch(8'h73);
    finish(8'h73, "ignore73", 3, 8'h11, 1'b0, '0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("ignore73.extra_done", dn, 0);
    chk("ignore73.idle_busy", busy, 0);

    // An asynchronous reset in the middle of a conversion aborts it.
    launch(8'h58);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.bin_out", bin_out, 0);
    chk("abort.done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    chk("abort.no_activity", dn, 0);
    conv(8'h58, "after_abort58");

    // Back-to-back: the request held during the done cycle starts the next
    // conversion with no idle gap.
    launch(8'h21);
    finish(8'h21, "b2b21", -5, '0, 1'b1, 8'h64);
    finish(8'h64, "b2b64", -5, '0, 1'b0, '0);

    // Sweep every valid two-digit input.
    for (int t = 0; t < 100; t++) begin
      r = {4'(t / 10), 4'(t % 10)};
      conv(r, "sweep");
    end

    // Random nibbles, including illegal digits.
    for (int k = 0; k < 40; k++) begin
      r = BW'($urandom);
      conv(r, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
